// File: rtl/udp_stream_framer_pkg.sv
// ---------------------------------------------------------------------------
// udp_stream_framer_pkg
// Shared definitions for the UDP transmit framing path:
//   - state_e        : framer FSM state encoding
//   - MAGIC_DEFAULT  : first byte of every packet header
//   - HDR_LEN        : header length in bytes (magic, fifo index, seq hi, seq lo)
//   - STAT_*         : bit layout of the 96-bit tx status word
//   - pack_status()  : assembles a status word from its fields
// ---------------------------------------------------------------------------
package udp_stream_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_REQ   = 3'd2,
        ST_RD    = 3'd3,
        ST_BYTES = 3'd4,
        ST_STAT  = 3'd5
    } state_e;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
    localparam int         HDR_LEN       = 4;

    // Status word: {MAC[95:48], IP[47:16], LEN[15:0]}
    localparam int STAT_W       = 96;
    localparam int STAT_MAC_LSB = 48;
    localparam int STAT_MAC_W   = 48;
    localparam int STAT_IP_LSB  = 16;
    localparam int STAT_IP_W    = 32;
    localparam int STAT_LEN_LSB = 0;
    localparam int STAT_LEN_W   = 16;

    function automatic logic [STAT_W-1:0] pack_status(
        input logic [STAT_MAC_W-1:0] mac,
        input logic [STAT_IP_W-1:0]  ip,
        input logic [STAT_LEN_W-1:0] len
    );
        logic [STAT_W-1:0] word;
        word = '0;
        word[STAT_MAC_LSB +: STAT_MAC_W] = mac;
        word[STAT_IP_LSB  +: STAT_IP_W]  = ip;
        word[STAT_LEN_LSB +: STAT_LEN_W] = len;
        return word;
    endfunction

endpackage

// File: rtl/udp_stream_framer_rr_fifo_select.sv
// ---------------------------------------------------------------------------
// rr_fifo_select
// Combinational round-robin search over a bundle of FIFO empty flags.
// Returns the lowest-indexed non-empty FIFO at or above rr_ptr_i; if none
// exists above the pointer, the search wraps and returns the lowest-indexed
// non-empty FIFO overall.
// Ports:
//   rdempty_i   in  N_FIFOS  per-FIFO empty flags
//   rr_ptr_i    in  SEL_W    round-robin start position
//   sel_o       out SEL_W    selected FIFO index (valid when any_ready_o)
//   any_ready_o out 1        at least one FIFO is non-empty
// ---------------------------------------------------------------------------
module rr_fifo_select #(
    parameter int N_FIFOS = 7,
    parameter int SEL_W   = 3
) (
    input  logic [N_FIFOS-1:0] rdempty_i,
    input  logic [SEL_W-1:0]   rr_ptr_i,
    output logic [SEL_W-1:0]   sel_o,
    output logic               any_ready_o
);

    logic [N_FIFOS-1:0] ready;
    logic [N_FIFOS-1:0] upper;   // ready and at/after the pointer
    logic [SEL_W-1:0]   sel_upper;
    logic [SEL_W-1:0]   sel_any;

    generate
        for (genvar gi = 0; gi < N_FIFOS; gi++) begin : g_cand
            assign ready[gi] = ~rdempty_i[gi];
            assign upper[gi] = ready[gi] & (SEL_W'(gi) >= rr_ptr_i);
        end
    endgenerate

    // Scanning from the top down lets the lowest qualifying index win.
    always_comb begin
        sel_upper = '0;
        sel_any   = '0;
        for (int k = N_FIFOS - 1; k >= 0; k--) begin
            if (upper[k]) sel_upper = SEL_W'(k);
            if (ready[k]) sel_any   = SEL_W'(k);
        end
        any_ready_o = |ready;
        sel_o       = (|upper) ? sel_upper : sel_any;
    end

endmodule

// File: rtl/udp_stream_framer.sv
// ---------------------------------------------------------------------------
// udp_stream_framer
// Transmit framing stage for UDP port 2. Drains the sample FIFOs in
// round-robin order and serialises one burst per packet onto the 8-bit eth
// tx data FIFO, followed by one 96-bit status word.
// Packet: MAGIC, fifo index, seq[15:8], seq[7:0], then N words MSB byte first.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   stream_enable, dest_valid    packet start permission
//   destination_mac/ip           copied into the status word at packet start
//   rdreq_fifo/rddata_fifo/rdempty_fifo  sample FIFO bundle (normal read mode)
//   tx_fifo_data/_write/_full    payload byte stream
//   tx_fifo_status/_write/_full  {mac, ip, length} per packet
//   packet_count                 sequence number of the next packet
//   busy                         framer not idle
// ---------------------------------------------------------------------------
module udp_stream_framer
    import udp_stream_framer_pkg::*;
#(
    parameter int         FIFO_LENGTH      = 16,
    parameter int         nOfFifos         = 7,
    parameter int         WORDS_PER_PACKET = 64,
    parameter int         FLUSH_TIMEOUT    = 125000,
    parameter logic [7:0] MAGIC            = MAGIC_DEFAULT
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            stream_enable,
    input  logic                            dest_valid,
    input  logic [47:0]                     destination_mac,
    input  logic [31:0]                     destination_ip,
    output logic [nOfFifos-1:0]             rdreq_fifo,
    input  logic [nOfFifos*FIFO_LENGTH-1:0] rddata_fifo,
    input  logic [nOfFifos-1:0]             rdempty_fifo,
    output logic [7:0]                      tx_fifo_data,
    output logic                            tx_fifo_data_write,
    input  logic                            tx_fifo_data_full,
    output logic [95:0]                     tx_fifo_status,
    output logic                            tx_fifo_status_write,
    input  logic                            tx_fifo_status_full,
    output logic [15:0]                     packet_count,
    output logic                            busy
);

    localparam int SEL_W  = (nOfFifos > 1) ? $clog2(nOfFifos) : 1;
    localparam int BPW    = FIFO_LENGTH / 8;
    localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TO_W   = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

    state_e                 state_q,    state_d;
    logic [SEL_W-1:0]       sel_q,      sel_d;
    logic [SEL_W-1:0]       rr_ptr_q,   rr_ptr_d;
    logic [47:0]            mac_q,      mac_d;
    logic [31:0]            ip_q,       ip_d;
    logic [1:0]             hdr_idx_q,  hdr_idx_d;
    logic [FIFO_LENGTH-1:0] word_q,     word_d;
    logic [BIDX_W-1:0]      byte_idx_q, byte_idx_d;
    logic [7:0]             count_q,    count_d;
    logic [TO_W-1:0]        timeout_q,  timeout_d;
    logic [15:0]            seq_q,      seq_d;

    logic                   rd_strobe;
    logic [SEL_W-1:0]       sel_next;
    logic                   any_ready;
    logic [7:0]             hdr_byte;
    logic [15:0]            pkt_len;
    logic [FIFO_LENGTH-1:0] fifo_word [nOfFifos];

    rr_fifo_select #(
        .N_FIFOS (nOfFifos),
        .SEL_W   (SEL_W)
    ) u_rr_fifo_select (
        .rdempty_i   (rdempty_fifo),
        .rr_ptr_i    (rr_ptr_q),
        .sel_o       (sel_next),
        .any_ready_o (any_ready)
    );

    generate
        for (genvar gi = 0; gi < nOfFifos; gi++) begin : g_fifo
            assign fifo_word[gi]  = rddata_fifo[gi*FIFO_LENGTH +: FIFO_LENGTH];
            assign rdreq_fifo[gi] = rd_strobe & (sel_q == SEL_W'(gi));
        end
    endgenerate

    always_comb begin
        hdr_byte = MAGIC;
        case (hdr_idx_q)
            2'd0:    hdr_byte = MAGIC;
            2'd1:    hdr_byte = 8'(sel_q);
            2'd2:    hdr_byte = seq_q[15:8];
            default: hdr_byte = seq_q[7:0];
        endcase
    end

    assign pkt_len      = 16'(HDR_LEN) + 16'(count_q) * 16'(BPW);
    assign packet_count = seq_q;
    assign busy         = (state_q != ST_IDLE);

    always_comb begin
        state_d              = state_q;
        sel_d                = sel_q;
        rr_ptr_d             = rr_ptr_q;
        mac_d                = mac_q;
        ip_d                 = ip_q;
        hdr_idx_d            = hdr_idx_q;
        word_d               = word_q;
        byte_idx_d           = byte_idx_q;
        count_d              = count_q;
        timeout_d            = timeout_q;
        seq_d                = seq_q;
        rd_strobe            = 1'b0;
        tx_fifo_data         = '0;
        tx_fifo_data_write   = 1'b0;
        tx_fifo_status       = '0;
        tx_fifo_status_write = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (stream_enable && dest_valid && !tx_fifo_status_full && any_ready) begin
                    sel_d     = sel_next;
                    mac_d     = destination_mac;
                    ip_d      = destination_ip;
                    hdr_idx_d = '0;
                    state_d   = ST_HDR;
                end
            end

            ST_HDR: begin
                if (!tx_fifo_data_full) begin
                    tx_fifo_data       = hdr_byte;
                    tx_fifo_data_write = 1'b1;
                    hdr_idx_d          = hdr_idx_q + 2'd1;
                    if (hdr_idx_q == 2'd3) begin
                        count_d   = '0;
                        timeout_d = '0;
                        state_d   = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                if (!rdempty_fifo[sel_q]) begin
                    // Hold off the fetch while the sink is full so no word
                    // sits captured while bytes cannot drain.
                    if (!tx_fifo_data_full) begin
                        rd_strobe = 1'b1;
                        timeout_d = '0;
                        state_d   = ST_RD;
                    end
                end else if ((count_q == 8'd0) || (timeout_q == TO_W'(FLUSH_TIMEOUT))
                             || !stream_enable) begin
                    state_d = ST_STAT;
                end else begin
                    timeout_d = timeout_q + TO_W'(1);
                end
            end

            ST_RD: begin
                word_d     = fifo_word[sel_q];
                byte_idx_d = '0;
                state_d    = ST_BYTES;
            end

            ST_BYTES: begin
                if (!tx_fifo_data_full) begin
                    // The word is shifted left after each byte so the next
                    // byte to send is always the top one.
                    tx_fifo_data       = word_q[FIFO_LENGTH-1 -: 8];
                    tx_fifo_data_write = 1'b1;
                    word_d             = word_q << 8;
                    byte_idx_d         = byte_idx_q + BIDX_W'(1);
                    if (byte_idx_q == BIDX_W'(BPW - 1)) begin
                        count_d = count_q + 8'd1;
                        if ((count_q + 8'd1) == 8'(WORDS_PER_PACKET)) begin
                            state_d = ST_STAT;
                        end else begin
                            state_d = ST_REQ;
                        end
                    end
                end
            end

            ST_STAT: begin
                tx_fifo_status = pack_status(mac_q, ip_q, pkt_len);
                if (!tx_fifo_status_full) begin
                    tx_fifo_status_write = 1'b1;
                    seq_d                = seq_q + 16'd1;
                    rr_ptr_d             = (sel_q == SEL_W'(nOfFifos - 1)) ? '0 : sel_q + SEL_W'(1);
                    state_d              = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            rr_ptr_q   <= '0;
            mac_q      <= '0;
            ip_q       <= '0;
            hdr_idx_q  <= '0;
            word_q     <= '0;
            byte_idx_q <= '0;
            count_q    <= '0;
            timeout_q  <= '0;
            seq_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rr_ptr_q   <= rr_ptr_d;
            mac_q      <= mac_d;
            ip_q       <= ip_d;
            hdr_idx_q  <= hdr_idx_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            count_q    <= count_d;
            timeout_q  <= timeout_d;
            seq_q      <= seq_d;
        end
    end

endmodule

// File: tb/tb_udp_stream_framer.sv
module tb_udp_stream_framer;

    localparam int NF    = 7;
    localparam int FL    = 16;
    localparam int DEPTH = 128;
    localparam logic [47:0] MAC = 48'h0011_2233_4455;
    localparam logic [31:0] IP  = 32'hC0A8_0102;

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;
    logic           stream_enable = 1'b0;
    logic           dest_valid = 1'b0;
    logic [NF-1:0]  rdreq_fifo;
    logic [NF*FL-1:0] rddata = '0;
    logic [NF-1:0]  rdempty;
    logic [7:0]     tx_fifo_data;
    logic           tx_fifo_data_write;
    logic           tx_fifo_data_full = 1'b0;
    logic [95:0]    tx_fifo_status;
    logic           tx_fifo_status_write;
    logic           tx_fifo_status_full = 1'b0;
    logic [15:0]    packet_count;
    logic           busy;

    udp_stream_framer #(
        .FIFO_LENGTH      (FL),
        .nOfFifos         (NF),
        .WORDS_PER_PACKET (64),
        .FLUSH_TIMEOUT    (100),
        .MAGIC            (8'hA5)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .stream_enable        (stream_enable),
        .dest_valid           (dest_valid),
        .destination_mac      (MAC),
        .destination_ip       (IP),
        .rdreq_fifo           (rdreq_fifo),
        .rddata_fifo          (rddata),
        .rdempty_fifo         (rdempty),
        .tx_fifo_data         (tx_fifo_data),
        .tx_fifo_data_write   (tx_fifo_data_write),
        .tx_fifo_data_full    (tx_fifo_data_full),
        .tx_fifo_status       (tx_fifo_status),
        .tx_fifo_status_write (tx_fifo_status_write),
        .tx_fifo_status_full  (tx_fifo_status_full),
        .packet_count         (packet_count),
        .busy                 (busy)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- sample FIFO model (normal read mode) ----------------
    logic [FL-1:0] mem [NF][DEPTH];
    int            wr_p [NF];
    int            rd_p [NF];
    logic          flush_req = 1'b0;

    generate
        for (genvar gi = 0; gi < NF; gi++) begin : g_empty
            assign rdempty[gi] = (rd_p[gi] == wr_p[gi]);
        end
    endgenerate

    always @(posedge clk) begin
        for (int k = 0; k < NF; k++) begin
            if (flush_req) begin
                rd_p[k] <= wr_p[k];
            end else if (rdreq_fifo[k] && (rd_p[k] != wr_p[k])) begin
                rddata[k*FL +: FL] <= mem[k][rd_p[k]];
                rd_p[k] <= rd_p[k] + 1;
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    logic [7:0]  exp_bytes [$];
    logic [95:0] exp_stat  [$];
    int data_cnt      = 0;
    int last_data_cyc = 0;
    int last_stat_cyc = 0;

    always @(negedge clk) begin
        if (tx_fifo_data_write) begin
            if (exp_bytes.size() == 0) chk("unexpected_byte", tx_fifo_data_write, 1'b0);
            else chk("data_byte", tx_fifo_data, exp_bytes.pop_front());
            data_cnt++;
            last_data_cyc = cyc;
        end
        if (tx_fifo_status_write) begin
            $display("packet: status %h seq_before=%0d cycle=%0d", tx_fifo_status, packet_count, cyc);
            if (exp_stat.size() == 0) chk("unexpected_status", tx_fifo_status_write, 1'b0);
            else chk("status_word", tx_fifo_status, exp_stat.pop_front());
            last_stat_cyc = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic fifo_push(input int f, input logic [15:0] w);
        mem[f][wr_p[f]] = w;
        wr_p[f] = wr_p[f] + 1;
    endtask

    task automatic exp_hdr(input logic [7:0] f, input logic [15:0] seq);
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(f);
        exp_bytes.push_back(seq[15:8]);
        exp_bytes.push_back(seq[7:0]);
    endtask

    task automatic exp_word(input logic [15:0] w);
        exp_bytes.push_back(w[15:8]);
        exp_bytes.push_back(w[7:0]);
    endtask

    task automatic exp_status(input logic [15:0] len);
        exp_stat.push_back({MAC, IP, len});
    endtask

    task automatic wait_pc(input logic [15:0] tgt, input int budget, input string name);
        int n = 0;
        while (packet_count !== tgt && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, packet_count, tgt);
    endtask

    task automatic wait_data(input int tgt, input int budget, input string name);
        int n = 0;
        while (data_cnt < tgt && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, (data_cnt >= tgt), 1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdreq"},    rdreq_fifo, '0);
        chk({tag, "_data"},     tx_fifo_data, '0);
        chk({tag, "_data_wr"},  tx_fifo_data_write, 1'b0);
        chk({tag, "_status"},   tx_fifo_status, '0);
        chk({tag, "_stat_wr"},  tx_fifo_status_write, 1'b0);
        chk({tag, "_pc"},       packet_count, '0);
        chk({tag, "_busy"},     busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        int dc0;

        // Reset state
        #2 reset_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // T1: FIFO 2, three words, flush after timeout; dest_valid gates start
        stream_enable = 1'b1;
        fifo_push(2, 16'h1234);
        fifo_push(2, 16'hABCD);
        fifo_push(2, 16'h0001);
        exp_hdr(8'h02, 16'h0000);
        exp_word(16'h1234); exp_word(16'hABCD); exp_word(16'h0001);
        exp_status(16'd10);
        repeat (5) @(negedge clk);
        chk("dest_valid_gate_busy", busy, 1'b0);
        chk("dest_valid_gate_rdreq", rdreq_fifo, '0);
        dest_valid = 1'b1;
        @(negedge clk);
        chk("start_latency_write", tx_fifo_data_write, 1'b1);
        chk("start_latency_magic", tx_fifo_data, 8'hA5);
        wait_pc(16'd1, 1000, "t1_packet_count");
        chk("t1_flush_delay", ((last_stat_cyc - last_data_cyc) inside {[101:103]}), 1'b1);

        // T2: FIFO 0 holds 70 words -> 64-word packet then 6-word packet
        for (int i = 0; i < 70; i++) fifo_push(0, 16'h0100 + 16'(i));
        exp_hdr(8'h00, 16'h0001);
        for (int i = 0; i < 64; i++) exp_word(16'h0100 + 16'(i));
        exp_status(16'd132);
        exp_hdr(8'h00, 16'h0002);
        for (int i = 64; i < 70; i++) exp_word(16'h0100 + 16'(i));
        exp_status(16'd16);
        wait_pc(16'd2, 1000, "t2_full_packet");
        wait_pc(16'd3, 1000, "t2_partial_packet");

        // T3: FIFOs 1,3,5 ready together -> order 1,3,5 then 1 again
        fifo_push(1, 16'h1111);
        fifo_push(3, 16'h3333);
        fifo_push(5, 16'h5555);
        exp_hdr(8'h01, 16'h0003); exp_word(16'h1111); exp_status(16'd6);
        exp_hdr(8'h03, 16'h0004); exp_word(16'h3333); exp_status(16'd6);
        exp_hdr(8'h05, 16'h0005); exp_word(16'h5555); exp_status(16'd6);
        exp_hdr(8'h01, 16'h0006); exp_word(16'h1112); exp_status(16'd6);
        wait_pc(16'd4, 1000, "t3_first_rr");
        fifo_push(1, 16'h1112);
        wait_pc(16'd7, 2000, "t3_rr_done");

        // T4: data FIFO full for 10 cycles mid-payload
        base = data_cnt;
        for (int i = 1; i <= 4; i++) fifo_push(4, 16'h4000 + 16'(i));
        exp_hdr(8'h04, 16'h0007);
        for (int i = 1; i <= 4; i++) exp_word(16'h4000 + 16'(i));
        exp_status(16'd12);
        wait_data(base + 7, 200, "t4_reach_stall_point");
        tx_fifo_data_full = 1'b1;
        dc0 = data_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_no_write", tx_fifo_data_write, 1'b0);
            chk("stall_no_rdreq", rdreq_fifo, '0);
        end
        chk("stall_byte_count_frozen", data_cnt, dc0);
        tx_fifo_data_full = 1'b0;
        wait_pc(16'd8, 1000, "t4_packet_done");

        // T5: sequence wrap FFFF -> 0000
        @(negedge clk);
        force dut.seq_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut.seq_q;
        @(negedge clk);
        chk("seq_preload", packet_count, 16'hFFFF);
        fifo_push(6, 16'h6666);
        exp_hdr(8'h06, 16'hFFFF); exp_word(16'h6666); exp_status(16'd6);
        wait_pc(16'h0000, 1000, "t5_seq_wrapped");
        fifo_push(6, 16'h6667);
        exp_hdr(8'h06, 16'h0000); exp_word(16'h6667); exp_status(16'd6);
        wait_pc(16'h0001, 1000, "t5_after_wrap");

        // T6: stream_enable drop closes the packet without timeout wait
        base = data_cnt;
        fifo_push(3, 16'h3A3B);
        exp_hdr(8'h03, 16'h0001); exp_word(16'h3A3B); exp_status(16'd6);
        wait_data(base + 6, 200, "t6_bytes_out");
        stream_enable = 1'b0;
        wait_pc(16'd2, 200, "t6_early_close");
        chk("t6_close_delay", ((last_stat_cyc - last_data_cyc) <= 4), 1'b1);
        stream_enable = 1'b1;

        // T7: reset mid-payload aborts, restart at seq 0
        base = data_cnt;
        fifo_push(5, 16'h5A01);
        fifo_push(5, 16'h5A02);
        fifo_push(5, 16'h5A03);
        exp_hdr(8'h05, 16'h0002);
        exp_word(16'h5A01); exp_word(16'h5A02); exp_word(16'h5A03);
        exp_status(16'd10);
        wait_data(base + 5, 200, "t7_mid_payload");
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("async_reset");
        exp_bytes.delete();
        exp_stat.delete();
        flush_req = 1'b1;
        @(posedge clk);
        #1 flush_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        fifo_push(2, 16'hBEEF);
        exp_hdr(8'h02, 16'h0000); exp_word(16'hBEEF); exp_status(16'd6);
        wait_pc(16'd1, 1000, "t7_restart_packet");

        repeat (5) @(negedge clk);
        chk("scoreboard_bytes_drained", exp_bytes.size(), 0);
        chk("scoreboard_status_drained", exp_stat.size(), 0);
        chk("final_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/udp_stream_framer.md
Name: udp_stream_framer

Overview:
- Transmit-side framing stage for UDP port 2.
- Drains the sample FIFOs that feed port 2 (nOfFifos × FIFO_LENGTH-bit words) in round-robin order and serialises each burst into one UDP payload on the 8-bit eth tx data FIFO, followed by one 96-bit tx status word.
- Runs in the rx_xcvr_clk domain, alongside the port-2 decoder, using the same FIFO-bundle port shapes.

Parameters:
- FIFO_LENGTH, 16, width of each sample word; must be a multiple of 8.
- nOfFifos, 7, number of sample FIFOs; range 1..255.
- WORDS_PER_PACKET, 64, maximum sample words per packet; range 1..255.
- FLUSH_TIMEOUT, 125000, idle cycles before a partial packet is closed (1 ms at 125 MHz).
- MAGIC, 8'hA5, first header byte.

Ports:
- clk  in  1  rx_xcvr_clk, 125 MHz.
- reset_n  in  1  asynchronous, active-low. Driven from mac_configured_125.
- stream_enable  in  1  level; permits new packets.
- dest_valid  in  1  client MAC/IP known; no packet starts while 0.
- destination_mac  in  48  copied into the status word.
- destination_ip  in  32  copied into the status word.
- rdreq_fifo  out  nOfFifos  one-hot read strobe. Read data is valid the cycle after the strobe (normal, not show-ahead).
- rddata_fifo  in  nOfFifos*FIFO_LENGTH  FIFO k occupies bits [k*FIFO_LENGTH +: FIFO_LENGTH].
- rdempty_fifo  in  nOfFifos  per-FIFO empty flag.
- tx_fifo_data  out  8  payload byte.
- tx_fifo_data_write  out  1  byte write strobe.
- tx_fifo_data_full  in  1  data FIFO full.
- tx_fifo_status  out  96  {destination_mac, destination_ip, length[15:0]}.
- tx_fifo_status_write  out  1  status write strobe.
- tx_fifo_status_full  in  1  status FIFO full.
- packet_count  out  16  sequence number of the next packet.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0; rr_ptr=0; seq=0; state IDLE.
  - reset_n low mid-packet aborts immediately.
  - A truncated byte stream with no status word is acceptable; the eth core discards data that has no status.
- Packet format: MAGIC, fifo index, seq[15:8], seq[7:0], then N words, each MSB byte first.
  - length = 4 + N*(FIFO_LENGTH/8).
  - seq wraps 16'hFFFF→0. It increments on status write.
- IDLE:
  - Start condition: stream_enable & dest_valid & !tx_fifo_status_full & any !rdempty_fifo.
  - Select the first non-empty FIFO at or after rr_ptr, modulo nOfFifos.
  - Latch sel, destination_mac and destination_ip; go to HDR.
- HDR: write the 4 header bytes, one per cycle, only while !tx_fifo_data_full. Hold the byte and index on full.
- REQ:
  - If !rdempty_fifo[sel]: pulse rdreq_fifo[sel] for exactly one cycle → RD.
  - Else if count==0 or the timeout counter has reached FLUSH_TIMEOUT: → STAT, with count==0 permitted only after the header.
  - Else increment the timeout counter. It clears on every accepted word.
  - If stream_enable falls while in REQ with FIFO empty: close immediately → STAT, no timeout wait.
- RD: capture rddata_fifo[sel] the cycle after rdreq → BYTES.
- BYTES:
  - Emit FIFO_LENGTH/8 bytes MSB first, each gated by !tx_fifo_data_full.
  - Then count++. If count==WORDS_PER_PACKET → STAT, else → REQ.
- STAT:
  - Wait for !tx_fifo_status_full, then pulse tx_fifo_status_write for 1 cycle with the status word.
  - seq++; rr_ptr = sel+1 (wrap to 0 at nOfFifos) → IDLE.
- A packet whose sel FIFO empties before its first word still carries a header. STAT sends length=4, a valid empty-data packet.
- Never more than one rdreq outstanding. No rdreq is issued while the captured word is unsent.
- Latency: first header byte is written 1 cycle after the start condition, with no backpressure.
- Simultaneous rdempty deassertion on several FIFOs: lowest index ≥ rr_ptr wins.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, HDR, REQ, RD, BYTES, STAT);
  - MAGIC;
  - header length constant (4);
  - status-word field offsets (MAC 95:48, IP 47:16, LEN 15:0).
- One natural sub-module: rr_fifo_select. Combinational priority search from rr_ptr over rdempty_fifo, returning sel and any_ready. Reused by future tx ports.

Test Plan:
- FIFO 2 holds 3 words (0x1234, 0xABCD, 0x0001); no more data; FLUSH_TIMEOUT=100.
  - Expect bytes A5 02 00 00 12 34 AB CD 00 01.
  - Status write ≈100 cycles after the last word, length=10.
  - packet_count becomes 1.
- FIFO 0 holds 70 words.
  - First packet: 64 words, length=132, seq 0.
  - Second packet: 6 words after timeout, seq 1.
  - Header byte 1 = 00 both times.
- FIFOs 1, 3 and 5 all non-empty with rr_ptr=0.
  - Expect packets in order 1, 3, 5, then 1 again.
- tx_fifo_data_full held high for 10 cycles mid-payload.
  - No write strobes and no rdreq during the stall.
  - Byte sequence unchanged; no duplicate or lost bytes.
- seq preloaded to 0xFFFF by sending 65535 packets (or force).
  - Header bytes FF FF, then next packet 00 00.
- reset_n asserted during BYTES.
  - All outputs 0 asynchronously, no status write.
  - After release the first packet carries seq 0 and the header restarts at MAGIC.
